// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for an 8-channel SPI SAR converter: CONVST pulse, 12-bit shift
// with a 6-bit config word, and a one-entry result holding register with overflow.
module adc_scan_sequencer #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80,
    parameter int GAP_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    output logic        adc_cs,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [11:0] sample_data,
    output logic [2:0]  sample_ch,
    output logic        overflow,
    input  logic        clr_overflow
);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, GAP} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic        sclk;
    logic [11:0] shreg;
    logic [2:0]  cur_ch, prev_ch, pend_ch;
    logic        prev_valid, load_pend;
    logic [5:0]  cfg;
    logic        start_scan, conv_done, half_done, sclk_rise, sclk_fall, shift_done, gap_done;

    // First set mask bit at or after start, searching upward and wrapping 7->0.
    function automatic logic [2:0] next_set(input logic [7:0] mask, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        next_set = start;
        found    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && mask[idx]) begin
                next_set = idx;
                found    = 1'b1;
            end
        end
    endfunction

    assign start_scan = enable && (ch_mask != 8'd0);
    assign conv_done  = (state == CONV) && (cnt == 16'(CONV_CYCLES - 1));
    assign gap_done   = (state == GAP) && (cnt == 16'(GAP_CYCLES - 1));
    assign half_done  = (state == SHIFT) && (div_cnt == 8'(CLK_DIV - 1));
    assign sclk_rise  = half_done && !sclk;
    assign sclk_fall  = half_done && sclk;
    assign shift_done = sclk_fall && (bit_cnt == 4'd11);

    // Single-ended, unipolar, no sleep; channel bits in the converter's odd order.
    assign cfg = {1'b1, cur_ch[0], cur_ch[2], cur_ch[1], 1'b1, 1'b0};

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        adc_cs    = 1'b0;
        adc_din   = 1'b0;
        case (state)
            IDLE:  if (start_scan) state_nxt = CONV;
            CONV: begin
                adc_cs = 1'b1;
                if (conv_done) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt < 4'd6) adc_din = cfg[3'd5 - bit_cnt[2:0]];
                if (shift_done) state_nxt = GAP;
            end
            GAP:   if (gap_done) state_nxt = start_scan ? CONV : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign adc_sclk = sclk;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            shreg   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) cnt <= '0;
            else if (state == CONV || state == GAP) cnt <= cnt + 16'd1;

            if (state == SHIFT) begin
                if (half_done) begin
                    div_cnt <= '0;
                    sclk    <= ~sclk;
                    if (sclk_fall) bit_cnt <= bit_cnt + 4'd1;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
                if (sclk_rise) shreg <= {shreg[10:0], adc_dout};
            end else begin
                div_cnt <= '0;
                bit_cnt <= '0;
                sclk    <= 1'b0;
            end
        end
    end

    // Channel tracking: a frame's result belongs to the channel configured one frame earlier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_ch     <= '0;
            prev_ch    <= '0;
            pend_ch    <= '0;
            prev_valid <= 1'b0;
            load_pend  <= 1'b0;
        end else begin
            if ((state == IDLE || state == GAP) && state_nxt == CONV)
                cur_ch <= next_set(ch_mask, (state == IDLE) ? cur_ch : cur_ch + 3'd1);
            load_pend <= 1'b0;
            if (shift_done) begin
                load_pend  <= prev_valid;
                pend_ch    <= prev_ch;
                prev_ch    <= cur_ch;
                prev_valid <= 1'b1;
            end else if (state == IDLE) begin
                prev_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_valid <= 1'b0;
            sample_data  <= '0;
            sample_ch    <= '0;
            overflow     <= 1'b0;
        end else begin
            if (load_pend && (!sample_valid || sample_ready)) begin
                sample_data  <= shreg;
                sample_ch    <= pend_ch;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            // A drop outranks a simultaneous clear.
            if (load_pend && sample_valid && !sample_ready) overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

endmodule
